// File: rtl/acb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : acb_mem_responder
// Brief    : Single-outstanding ACB memory responder backed by a byte-masked
//            64-bit RAM. Define ACB_MEM_ADDR_CHECK_EN to flag out-of-range or
//            misaligned addresses as errors.
// Revision : 1.0 - initial release
// ============================================================================
module acb_mem_responder #(
    parameter int MEM_DEPTH_LOG2 = 9
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    input  logic         ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  logic [109:0] ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    output logic         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    input  logic         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
    output logic [64:0]  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    output logic         acb_busy,
    output logic [15:0]  acb_access_count
);

    localparam int c_DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t                    r_state;
    logic                      r_read_req;
    logic                      r_write_req;
    logic [64:0]               r_write_data;
    logic                      r_busy;
    logic [15:0]               r_count;
    logic                      r_is_read;
    logic [7:0]                r_mask;
    logic [35:0]               r_addr;
    logic [63:0]               r_wdata;
    logic [63:0]               r_mem [0:c_DEPTH-1];

    logic                      w_take;
    logic                      w_addr_err;
    logic                      w_do_write;
    logic [MEM_DEPTH_LOG2-1:0] w_index;
    logic                      w_unused;

    assign w_take  = r_read_req & ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack;
    assign w_index = r_addr[MEM_DEPTH_LOG2+2:3];

`ifdef ACB_MEM_ADDR_CHECK_EN
    assign w_addr_err = (|r_addr[35:MEM_DEPTH_LOG2+3]) | (|r_addr[2:0]);
`else
    assign w_addr_err = 1'b0;
`endif

    // Lock bit and out-of-word address bits carry no meaning in the default build.
    assign w_unused = ^{ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data[109],
                        r_addr[35:MEM_DEPTH_LOG2+3], r_addr[2:0]};

    // Gated on ACCESS so an async reset during ACCESS suppresses the write.
    assign w_do_write = (r_state == ST_ACCESS) & ~r_is_read & ~w_addr_err;

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (r_mask[i]) begin
                    r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_read_req   <= 1'b0;
            r_write_req  <= 1'b0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_is_read    <= 1'b0;
            r_mask       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_is_read  <= ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data[108];
                        r_mask     <= ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data[107:100];
                        r_addr     <= ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data[99:64];
                        r_wdata    <= ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data[63:0];
                        r_read_req <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACCESS;
                    end else begin
                        r_read_req <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (w_addr_err) begin
                        r_write_data <= {1'b1, 64'h0};
                    end else if (r_is_read) begin
                        r_write_data <= {1'b0, r_mem[w_index]};
                    end else begin
                        r_write_data <= '0;
                    end
                    r_write_req <= 1'b1;
                    r_state     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack) begin
                        r_write_req <= 1'b0;
                        r_busy      <= 1'b0;
                        r_read_req  <= 1'b1;
                        r_count     <= r_count + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    = r_read_req;
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  = r_write_req;
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data = r_write_data;
    assign acb_busy                                     = r_busy;
    assign acb_access_count                             = r_count;

endmodule
`default_nettype wire

// File: tb/tb_acb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_acb_mem_responder
// Brief    : Directed and randomized bench for acb_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acb_mem_responder;

    localparam int DL2   = 9;
    localparam int WORDS = 1 << DL2;

    logic         clk;
    logic         rst_n;
    logic         rd_req;
    logic         rd_ack;
    logic [109:0] rd_data;
    logic         wr_req;
    logic         wr_ack;
    logic [64:0]  wr_data;
    logic         busy;
    logic [15:0]  cnt;

    int           n_cmp;
    int           n_err;
    logic [63:0]  ref_mem [0:WORDS-1];
    logic [15:0]  ref_count;

    acb_mem_responder #(.MEM_DEPTH_LOG2(DL2)) dut (
        .clk                                         (clk),
        .reset                                       (rst_n),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   (rd_req),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   (rd_ack),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  (rd_data),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req (wr_req),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack (wr_ack),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(wr_data),
        .acb_busy                                    (busy),
        .acb_access_count                            (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: decode, flag, then read or byte-merge into the word array.
    function automatic logic [64:0] model_txn(input bit rd, input logic [7:0] m,
                                              input logic [35:0] a, input logic [63:0] wd);
        int idx;
        bit err;
        idx = int'(a[DL2+2:3]);
        err = 1'b0;
`ifdef ACB_MEM_ADDR_CHECK_EN
        err = ((a >> (DL2 + 3)) != 36'h0) || (a[2:0] != 3'h0);
`endif
        if (err) return {1'b1, 64'h0};
        if (rd) return {1'b0, ref_mem[idx]};
        for (int i = 0; i < 8; i++) begin
            if (m[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
        end
        return 65'h0;
    endfunction

    // Entered and left on a falling edge with the DUT idle.
    task automatic txn(input bit rd, input logic [7:0] m, input logic [35:0] a,
                       input logic [63:0] wd, input int hold, output logic [64:0] resp);
        int t;
        logic [64:0] exp;
        t = 0;
        rd_data = {1'b0, rd, m, a, wd};
        rd_ack  = 1'b1;
        while (rd_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_ready", 65'(rd_req), 65'(1));
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = ~rd_data;
        check("access_rdreq", 65'(rd_req), 65'(0));
        check("access_wrreq", 65'(wr_req), 65'(0));
        check("access_busy", 65'(busy), 65'(1));
        @(negedge clk);
        check("latency_wrreq", 65'(wr_req), 65'(1));
        resp = wr_data;
        exp  = model_txn(rd, m, a, wd);
        check("resp_data", wr_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_wrreq", 65'(wr_req), 65'(1));
            check("hold_data", wr_data, resp);
            check("hold_rdreq", 65'(rd_req), 65'(0));
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        ref_count++;
        check("count", 65'(cnt), 65'(ref_count));
        check("idle_busy", 65'(busy), 65'(0));
        check("idle_rdreq", 65'(rd_req), 65'(1));
        check("idle_wrreq", 65'(wr_req), 65'(0));
    endtask

    initial begin
        logic [64:0] r;
        logic [64:0] r2;
        logic [63:0] prior;
        logic [35:0] a;
        int t;
        n_cmp = 0;
        n_err = 0;
        ref_count = 16'h0;
        rst_n = 1'b0;
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        rd_data = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'h0;

        @(negedge clk);
        @(negedge clk);
        check("rst_rdreq", 65'(rd_req), 65'(0));
        check("rst_wrreq", 65'(wr_req), 65'(0));
        check("rst_wrdata", wr_data, 65'h0);
        check("rst_busy", 65'(busy), 65'(0));
        check("rst_count", 65'(cnt), 65'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("first_rdreq", 65'(rd_req), 65'(1));

        txn(1'b0, 8'hFF, 36'h10, 64'h1122334455667788, 0, r);
        txn(1'b1, 8'h00, 36'h10, 64'h0, 0, r);
        check("wr_rd_data", r, {1'b0, 64'h1122334455667788});
        check("wr_rd_count", 65'(cnt), 65'(2));

        txn(1'b0, 8'h0F, 36'h10, 64'hAAAAAAAAAAAAAAAA, 0, r);
        check("write_resp_zero", r, 65'h0);
        txn(1'b1, 8'h00, 36'h10, 64'h0, 5, r);
        check("partial_mask", r, {1'b0, 64'h11223344AAAAAAAA});

        for (int i = 0; i < WORDS; i++) begin
            txn(1'b0, 8'hFF, 36'(i) << 3, {$urandom, $urandom}, 0, r);
        end

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                a[31:0]  = $urandom;
                a[35:32] = 4'($urandom);
            end else begin
                a = 36'($urandom_range(0, WORDS - 1)) << 3;
            end
            txn(1'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom), a,
                {$urandom, $urandom}, int'($urandom_range(0, 2)), r);
        end

        txn(1'b0, 8'h0F, 36'h10, 64'h0123456789ABCDEF, 0, r);
        check("mask_zero_resp", r, 65'h0);
`ifdef ACB_MEM_ADDR_CHECK_EN
        txn(1'b1, 8'h00, 36'h1000, 64'h0, 0, r);
        check("err_high_addr", r, {1'b1, 64'h0});
        txn(1'b1, 8'h00, 36'h13, 64'h0, 0, r);
        check("err_unaligned", r, {1'b1, 64'h0});
        txn(1'b0, 8'hFF, 36'h1010, 64'hFFFFFFFFFFFFFFFF, 0, r);
        check("err_write_flag", r, {1'b1, 64'h0});
        txn(1'b1, 8'h00, 36'h10, 64'h0, 0, r2);
        check("err_no_modify", r2, {1'b0, ref_mem[2]});
`else
        txn(1'b1, 8'h00, 36'h1010, 64'h0, 0, r);
        txn(1'b1, 8'h00, 36'h10, 64'h0, 0, r2);
        check("alias_1010", r, r2);
        check("alias_err0", 65'(r[64]), 65'(0));
`endif

        // Abort a write while it sits in ACCESS.
        prior = ref_mem[2];
        check("pre_rst_rdreq", 65'(rd_req), 65'(1));
        rd_data = {1'b0, 1'b0, 8'hFF, 36'h10, 64'hDEADBEEFCAFEF00D};
        rd_ack  = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check("pre_rst_busy", 65'(busy), 65'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 65'(busy), 65'(0));
        check("mid_rst_rdreq", 65'(rd_req), 65'(0));
        check("mid_rst_count", 65'(cnt), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ref_count = 16'h0;
        @(negedge clk);
        check("post_rst_rdreq", 65'(rd_req), 65'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", 65'(wr_req), 65'(0));
        end
        txn(1'b1, 8'h00, 36'h10, 64'h0, 0, r);
        check("post_rst_prior", r, {1'b0, prior});

        // Free-running reads until the completion counter wraps.
        rd_data = {1'b0, 1'b1, 8'h00, 36'h10, 64'h0};
        rd_ack  = 1'b1;
        wr_ack  = 1'b1;
        t = 0;
        while (cnt != 16'hFFFF && t < 250000) begin
            @(negedge clk);
            t++;
        end
        check("wrap_reach_ffff", 65'(cnt), 65'(16'hFFFF));
        t = 0;
        while (cnt == 16'hFFFF && t < 10) begin
            @(negedge clk);
            t++;
        end
        rd_ack = 1'b0;
        wr_ack = 1'b0;
        check("wrap_zero", 65'(cnt), 65'(0));
        ref_count = 16'h0;
        txn(1'b1, 8'h00, 36'h10, 64'h0, 0, r);
        check("after_wrap_data", r, {1'b0, prior});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acb_mem_responder.md
ACB_MEM_RESPONDER -- requirements
Module: acb_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH_LOG2, default 9, giving the log2 of the number of 64-bit words in the internal memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req, output, 1 bit: the responder is ready to take a request.
REQ-005 The block SHALL have port ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack, input, 1 bit: the accelerator presents a valid request.
REQ-006 The block SHALL have port ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data, input, 110 bits, laid out as follows:
- [109]: lock, ignored.
- [108]: 1 = read, 0 = write.
- [107:100]: byte mask.
- [99:64]: byte address.
- [63:0]: write data.
REQ-007 The block SHALL have port ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req, output, 1 bit: a response is valid.
REQ-008 The block SHALL have port ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack, input, 1 bit: the accelerator takes the response.
REQ-009 The block SHALL have port ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data, output, 65 bits: [64] error, [63:0] read data.
REQ-010 The block SHALL have port acb_busy, output, 1 bit: high in every state other than IDLE.
REQ-011 The block SHALL have port acb_access_count, output, 16 bits: the number of completed transactions.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, ACCESS and RESPOND.
REQ-013 In IDLE, read_req SHALL be 1; a request SHALL transfer in the cycle where read_req and read_ack are both 1.
REQ-014 On transfer, the block SHALL register the request and go to ACCESS; read_req SHALL be 0 in ACCESS and in RESPOND.
REQ-015 In ACCESS, which lasts exactly 1 cycle, the block SHALL perform the memory operation, form the response, and go to RESPOND.
REQ-016 The word index SHALL be address[MEM_DEPTH_LOG2+2:3].
REQ-017 A write SHALL update byte i ([8i+7:8i]) only where mask[i]=1; mask 0x00 SHALL leave memory unchanged and still produce a response.
REQ-018 A read SHALL return the full 64-bit word, ignoring the mask.
REQ-019 A write response SHALL have data 0.
REQ-020 In RESPOND, write_req SHALL be 1 with data held stable until write_ack=1, then the block SHALL return to IDLE.
REQ-021 Latency: for a transfer at cycle N, write_req SHALL first be high at cycle N+2; the next transfer SHALL occur no earlier than the cycle after the response ack.
REQ-022 acb_access_count SHALL increment on each response handshake and wrap from 0xFFFF to 0x0000.
REQ-023 A read at the same word immediately after a write SHALL return the written data.

Reset
REQ-024 While reset=0, the block SHALL be in IDLE, with read_req=0, write_req=0, write_data=0, acb_busy=0 and acb_access_count=0.
REQ-025 The first read_req=1 SHALL appear in the first cycle after reset deasserts.
REQ-026 A reset mid-transaction SHALL discard the transaction with no response and no partial write after reset.
REQ-027 Memory contents SHALL NOT be reset.

Configuration
REQ-028 With ACB_MEM_ADDR_CHECK_EN defined, a request SHALL be flagged as an error if address[35:MEM_DEPTH_LOG2+3] is nonzero or address[2:0] is nonzero.
REQ-029 With ACB_MEM_ADDR_CHECK_EN defined, a flagged request SHALL return error=1 and data 0, and SHALL NOT modify memory.
REQ-030 Without ACB_MEM_ADDR_CHECK_EN, high address bits and address[2:0] SHALL be ignored (the address wraps modulo the memory size), and error SHALL always be 0.

Verification
REQ-031 The bench SHALL cover: write addr 0x10, mask 0xFF, data 0x1122334455667788, then read addr 0x10 -> read response data 0x1122334455667788, error 0, acb_access_count=2.
REQ-032 The bench SHALL cover: write addr 0x10, mask 0x0F, data 0xAAAAAAAAAAAAAAAA over the previous word, then read -> 0x11223344AAAAAAAA.
REQ-033 The bench SHALL cover: hold write_ack=0 for 5 cycles in RESPOND -> write_req and data stable, read_req=0 throughout, the next transfer no earlier than 1 cycle after the ack.
REQ-034 The bench SHALL cover: with ACB_MEM_ADDR_CHECK_EN, read addr 0x1000 and read addr 0x13 -> error=1, data 0; without the macro, read 0x1010 -> same word as 0x10.
REQ-035 The bench SHALL cover: reset=0 asserted during ACCESS of a write -> no response after reset; a later read of that word returns its prior value.
REQ-036 The bench SHALL cover: 65536 transactions -> acb_access_count wraps to 0x0000.
